// File: rtl/seg_scan_driver_if.sv
// Bundle between the stopwatch counters (master) and the seven-segment scan driver (slave).
// Counter side supplies digits, masks and enables; driver side returns the pin-level scan outputs.
interface seg_scan_driver_if #(
  parameter int DIGITS = 4,
  parameter int POS_W  = $clog2(DIGITS)
);
  logic                  en;
  logic                  blank_en;
  logic [4*DIGITS-1:0]   nums;
  logic [DIGITS-1:0]     dp_mask;
  logic [POS_W-1:0]      pos;
  logic [3:0]            num;
  logic                  point;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     an;

  modport master (
    output en, blank_en, nums, dp_mask,
    input  pos, num, point, seg, an
  );

  modport slave (
    input  en, blank_en, nums, dp_mask,
    output pos, num, point, seg, an
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: prescaled digit scan, per-frame input snapshot,
// decimal-point mask, optional leading-zero blanking and active-low hex decode.
module seg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1,
  parameter int POS_W    = $clog2(DIGITS)
) (
  input  logic             clk_dvid,
  input  logic             rst_n,
  seg_scan_driver_if.slave bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      4'hF: hex_seg = 7'h0E;
    endcase
  endfunction

  // Walk from the most significant digit down; a digit blanks while everything above it is zero.
  function automatic logic [DIGITS-1:0] lead_blank(input logic [4*DIGITS-1:0] v, input logic ena);
    logic all_zero;
    lead_blank = '0;
    all_zero   = 1'b1;
    for (int unsigned i = 0; i < DIGITS - 1; i++) begin
      all_zero = all_zero & (v[4*(DIGITS-1-i) +: 4] == 4'h0);
      lead_blank[DIGITS-1-i] = ena & all_zero;
    end
  endfunction

  logic [DIV_W-1:0]    div;
  logic [POS_W-1:0]    pos_q;
  logic [POS_W-1:0]    nxt;
  logic                adv;
  logic                frame;
  logic [4*DIGITS-1:0] snap_num;
  logic [DIGITS-1:0]   snap_dp;
  logic [DIGITS-1:0]   blank;
  logic [4*DIGITS-1:0] cur_nums;
  logic [DIGITS-1:0]   cur_dp;
  logic [DIGITS-1:0]   cur_blank;
  logic [DIGITS-1:0]   new_blank;
  logic [3:0]          nib;
  logic [3:0]          num_q;
  logic                point_q;
  logic [6:0]          seg_q;
  logic [DIGITS-1:0]   an_q;

  always_comb begin
    adv       = bus.en & (div == DIV_W'(SCAN_DIV - 1));
    nxt       = (pos_q == POS_W'(DIGITS - 1)) ? '0 : pos_q + POS_W'(1);
    frame     = (nxt == '0);
    new_blank = lead_blank(bus.nums, bus.blank_en);
    // Digit 0 of a new frame is shown from the values being captured on this same edge.
    cur_nums  = frame ? bus.nums : snap_num;
    cur_dp    = frame ? bus.dp_mask : snap_dp;
    cur_blank = frame ? new_blank : blank;
    nib       = cur_nums[4*nxt +: 4];
  end

  always_ff @(posedge clk_dvid or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (bus.en) begin
      div <= adv ? '0 : div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_dvid or negedge rst_n) begin
    if (!rst_n) begin
      pos_q    <= POS_W'(DIGITS - 1);
      num_q    <= '0;
      point_q  <= 1'b0;
      seg_q    <= '1;
      an_q     <= '1;
      snap_num <= '0;
      snap_dp  <= '0;
      blank    <= '0;
    end else if (!bus.en) begin
      an_q <= '1;
    end else if (adv) begin
      pos_q   <= nxt;
      num_q   <= cur_blank[nxt] ? 4'h0 : nib;
      seg_q   <= cur_blank[nxt] ? 7'h7F : hex_seg(nib);
      point_q <= cur_dp[nxt];
      an_q    <= ~(DIGITS'(1) << nxt);
      if (frame) begin
        snap_num <= bus.nums;
        snap_dp  <= bus.dp_mask;
        blank    <= new_blank;
      end
    end
  end

  assign bus.pos   = pos_q;
  assign bus.num   = num_q;
  assign bus.point = point_q;
  assign bus.seg   = seg_q;
  assign bus.an    = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: two instances (SCAN_DIV 1 and 3) share stimulus and are
// checked every cycle against a frame-level model, plus hand-computed literal expectations.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en;
  logic        blank_en;
  logic [15:0] nums;
  logic [3:0]  dp_mask;

  always #5 clk = ~clk;

  seg_scan_driver_if #(.DIGITS(4)) ia ();
  seg_scan_driver_if #(.DIGITS(4)) ib ();

  assign ia.en = en;  assign ia.blank_en = blank_en;  assign ia.nums = nums;  assign ia.dp_mask = dp_mask;
  assign ib.en = en;  assign ib.blank_en = blank_en;  assign ib.nums = nums;  assign ib.dp_mask = dp_mask;

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(1)) dut_a (.clk_dvid(clk), .rst_n(rst_n), .bus(ia));
  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(3)) dut_b (.clk_dvid(clk), .rst_n(rst_n), .bus(ib));

  int checks = 0;
  int errors = 0;

  int seg_tab[16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                      'h00, 'h10, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: frame-level view of the display (which digit, what the captured frame holds).
  int       m_cnt[2];
  int       m_pos[2];
  bit       m_valid[2];
  bit       m_on[2];
  bit       m_blank[2];
  int       m_snap[2];
  bit [3:0] m_dp[2];

  function automatic int sd(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_cnt[i] <= 0; m_pos[i] <= 3; m_valid[i] <= 1'b0; m_on[i] <= 1'b0;
        m_blank[i] <= 1'b0; m_snap[i] <= 0; m_dp[i] <= 4'h0;
      end else if (!en) begin
        m_on[i] <= 1'b0;
      end else if (m_cnt[i] + 1 == sd(i)) begin
        m_cnt[i]   <= 0;
        m_pos[i]   <= (m_pos[i] + 1) % 4;
        m_on[i]    <= 1'b1;
        m_valid[i] <= 1'b1;
        if ((m_pos[i] + 1) % 4 == 0) begin
          m_snap[i]  <= int'(nums);
          m_dp[i]    <= dp_mask;
          m_blank[i] <= blank_en;
        end
      end else begin
        m_cnt[i] <= m_cnt[i] + 1;
      end
    end
  end

  task automatic expect_out(input int i, output int p, output int n, output int pt,
                            output int s, output int a);
    int d;
    bit blanked;
    p = m_pos[i];
    if (!m_valid[i]) begin
      n = 0; pt = 0; s = 'h7F; a = 'hF;
    end else begin
      d       = (m_snap[i] >> (4 * p)) & 'hF;
      blanked = m_blank[i] && p > 0 && ((m_snap[i] >> (4 * p)) == 0);
      n       = blanked ? 0 : d;
      s       = blanked ? 'h7F : seg_tab[d];
      pt      = int'(m_dp[i][p]);
      a       = m_on[i] ? ((~(1 << p)) & 'hF) : 'hF;
    end
  endtask

  task automatic cmp(input int i, input logic [31:0] p, input logic [31:0] n, input logic [31:0] pt,
                     input logic [31:0] s, input logic [31:0] a);
    int ep, en_, ept, es, ea;
    expect_out(i, ep, en_, ept, es, ea);
    chk($sformatf("model%0d_pos", i), p, ep);
    chk($sformatf("model%0d_num", i), n, en_);
    chk($sformatf("model%0d_point", i), pt, ept);
    chk($sformatf("model%0d_seg", i), s, es);
    chk($sformatf("model%0d_an", i), a, ea);
  endtask

  always @(posedge clk) begin
    #2;
    cmp(0, ia.pos, ia.num, ia.point, ia.seg, ia.an);
    cmp(1, ib.pos, ib.num, ib.point, ib.seg, ib.an);
  end

  // Literal checks; a negative expectation means "not checked here".
  task automatic chk_a(input string tag, input int p, input int n, input int s, input int pt, input int a);
    if (p >= 0)  chk({tag, "_a_pos"}, ia.pos, p);
    if (n >= 0)  chk({tag, "_a_num"}, ia.num, n);
    if (s >= 0)  chk({tag, "_a_seg"}, ia.seg, s);
    if (pt >= 0) chk({tag, "_a_point"}, ia.point, pt);
    if (a >= 0)  chk({tag, "_a_an"}, ia.an, a);
  endtask

  task automatic chk_b(input string tag, input int p, input int a);
    chk({tag, "_b_pos"}, ib.pos, p);
    chk({tag, "_b_an"}, ib.an, a);
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  int sn[4] = '{4, 3, 2, 1};
  int ss[4] = '{'h19, 'h30, 'h24, 'h79};
  int sp[4] = '{0, 1, 0, 0};
  int sa[4] = '{'hE, 'hD, 'hB, 'h7};

  initial begin
    en = 1'b1; blank_en = 1'b0; nums = 16'h1234; dp_mask = 4'b0010;
    step(); step();
    chk_a("reset", 3, 0, 'h7F, 0, 'hF);
    chk_b("reset", 3, 'hF);
    rst_n = 1'b1;

    for (int n = 1; n <= 8; n++) begin
      step();
      chk_a("scan", (n - 1) % 4, sn[(n - 1) % 4], ss[(n - 1) % 4], sp[(n - 1) % 4], sa[(n - 1) % 4]);
      if (n == 2) chk_b("pre_hold", 3, 'hF);
      if (n == 3) chk_b("pre_first", 0, 'hE);
    end

    rst_n = 1'b0;
    #1;
    chk_a("midreset", 3, 0, 'h7F, 0, 'hF);
    chk_b("midreset", 3, 'hF);
    step();
    rst_n = 1'b1;
    step(); chk_a("rel", 0, 4, 'h19, 0, 'hE);
    step(); chk_a("rel", 1, 3, 'h30, 1, 'hD);

    nums = 16'h9876;
    step(); chk_a("snap", 2, 2, 'h24, 0, 'hB);
    step(); chk_a("snap", 3, 1, 'h79, 0, 'h7);
    step(); chk_a("snap_new", 0, 6, 'h02, 0, 'hE);
    step(); chk_a("snap_new", 1, 7, 'h78, 1, 'hD);
    step(); chk_a("snap_new", 2, 8, 'h00, 0, 'hB);
    step(); chk_a("snap_new", 3, 9, 'h10, 0, 'h7);

    blank_en = 1'b1; nums = 16'h0050;
    step(); chk_a("blank50", 0, 0, 'h40, 0, 'hE);
    step(); chk_a("blank50", 1, 5, 'h12, 1, 'hD);
    step(); chk_a("blank50", 2, 0, 'h7F, 0, 'hB);
    step(); chk_a("blank50", 3, 0, 'h7F, 0, 'h7);
    nums = 16'h0000;
    step(); chk_a("blank00", 0, 0, 'h40, 0, 'hE);
    step(); chk_a("blank00", 1, 0, 'h7F, 1, 'hD);
    step(); chk_a("blank00", 2, 0, 'h7F, 0, 'hB);
    step(); chk_a("blank00", 3, 0, 'h7F, 0, 'h7);
    nums = 16'h0005;
    step(); chk_a("blank05", 0, 5, 'h12, 0, 'hE);
    step(); chk_a("blank05", 1, 0, 'h7F, 1, 'hD);
    step(); chk_a("blank05", 2, 0, 'h7F, 0, 'hB);
    step(); chk_a("blank05", 3, 0, 'h7F, 0, 'h7);

    step();
    blank_en = 1'b0; dp_mask = 4'b0001;
    step(); chk_a("midtoggle", 1, 0, 'h7F, 1, 'hD);
    step(); chk_a("midtoggle", 2, 0, 'h7F, 0, 'hB);
    step(); chk_a("midtoggle", 3, 0, 'h7F, 0, 'h7);
    step(); chk_a("newtoggle", 0, 5, 'h12, 1, 'hE);
    step(); chk_a("newtoggle", 1, 0, 'h40, 0, 'hD);
    step(); step();

    for (int v = 0; v < 16; v++) begin
      nums = 16'(v);
      step();
      chk_a($sformatf("sweep%0d", v), 0, v, seg_tab[v], 1, 'hE);
      step(); step(); step();
    end

    rst_n = 1'b0;
    #1;
    chk_b("reset2", 3, 'hF);
    step();
    nums = 16'h1234; dp_mask = 4'b0010;
    rst_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      chk_b($sformatf("div3_e%0d", n), (n < 3) ? 3 : ((n / 3) - 1) % 4,
            (n < 3) ? 'hF : sa[((n / 3) - 1) % 4]);
      chk_a($sformatf("div1_e%0d", n), (n - 1) % 4, -1, -1, -1, sa[(n - 1) % 4]);
    end
    en = 1'b0;
    for (int n = 13; n <= 17; n++) begin
      step();
      chk_b($sformatf("frozen_e%0d", n), 3, 'hF);
      chk_a($sformatf("frozen_e%0d", n), 3, 1, 'h79, 0, 'hF);
    end
    en = 1'b1;
    step(); chk_b("resume18", 3, 'hF); chk_a("resume18", 0, 4, 'h19, 0, 'hE);
    step(); chk_b("resume19", 3, 'hF);
    step(); chk_b("resume20", 0, 'hE); chk("resume20_b_seg", ib.seg, 'h19);

    step();
    en = 1'b0;
    step();
    en = 1'b1;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised multiplexed seven-segment scan driver for the stopwatch display path. It time-multiplexes `DIGITS` BCD/hex nibbles onto one shared segment bus, with the following features:
- an internal scan prescaler,
- frame-coherent input snapshotting,
- a per-digit decimal-point mask,
- optional leading-zero blanking,
- built-in hex-to-segment decode.

It sits between the stopwatch counters and the board's segment and anode pins.

## Interface
- `DIGITS`, 4: number of multiplexed digits (2..8).
- `SCAN_DIV`, 1: system-clock cycles per digit slot (≥1).
- `POS_W`, `$clog2(DIGITS)`: width of `pos`.
- `clk_dvid` input 1: scan/system clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: scan enable; low freezes scan and turns all anodes off.
- `blank_en` input 1: leading-zero blanking enable.
- `nums` input `4*DIGITS`: digit k = `nums[4k+3:4k]`; digit 0 is least significant.
- `dp_mask` input `DIGITS`: bit k lights the decimal point of digit k.
- `pos` output `POS_W`: index of the digit currently driven.
- `num` output 4: nibble currently driven (0 when blanked).
- `point` output 1: decimal point of the current digit, active-high.
- `seg` output 7: segments gfedcba (bit0 = a), active-low.
- `an` output `DIGITS`: digit anodes, active-low, one-hot.

## Operation
- Prescaler `div` counts `0..SCAN_DIV-1` while `en=1`. An advance occurs on the edge where `div==SCAN_DIV-1`. At that edge `div` wraps to 0.
- On each advance:
  - `pos` moves to `nxt = (pos==DIGITS-1) ? 0 : pos+1`.
  - All outputs are registered from `nxt` at the same edge, so `pos`, `num`, `point`, `seg` and `an` always agree.
- Frame snapshot: on an advance with `nxt==0`, `nums` and `dp_mask` are captured into `snap_num`/`snap_dp`, and the blank vector is recomputed from the captured value. Digit-0 outputs at that edge use the incoming values. Input changes mid-frame never appear until the next frame.
- Leading-zero blanking (`blank_en=1`, sampled with the snapshot):
  - Digit k (k≥1) is blanked iff snap nibbles k..DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit drives `seg=7'h7F`, `num=0` and `an[k]=0`. `point` still follows `snap_dp[k]`.
- Decode is active-low, hex 0–F: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E.
- `en=0`:
  - `div` and `pos` hold.
  - `an` goes to all ones on the next edge; `seg`, `num` and `point` hold.
  - The next advance after re-enable resumes from the held `pos`.

## Timing
- Reset (async assert, any time): `div=0`, `pos=DIGITS-1`, `num=0`, `point=0`, `seg=7'h7F`, `an=all ones`, snapshot and blank vector = 0.
- The first advance after reset release goes to digit 0 and loads the snapshot: at `clk_dvid` edge `SCAN_DIV` after reset release when `en=1` throughout.
- Each digit is held for exactly `SCAN_DIV` cycles. A full frame is `DIGITS*SCAN_DIV` cycles.
- Input-to-display latency: the value present at a frame-start edge shows on digit k exactly `k*SCAN_DIV` cycles later.
- Reset mid-frame aborts the frame immediately (outputs off, asynchronously). The next frame starts at digit 0 with a fresh snapshot.
- Toggling `blank_en` or `dp_mask` mid-frame takes effect only at the next frame start.
- `SCAN_DIV=1`: advance every cycle, `div` is constant 0.

## Test plan
- Reset check: assert `rst_n=0` mid-scan (DIGITS=4). Required immediately: `seg=7F`, `an=4'b1111`, `num=0`, `point=0`, `pos=3`. Release; after 1 cycle (SCAN_DIV=1): `pos=0`, `an=1110`.
- Scan order: `nums=16'h1234`, `dp_mask=4'b0010`, blank off, SCAN_DIV=1. Required repeating sequence:
  - pos0: num=4, seg=19, point=0.
  - pos1: num=3, seg=30, point=1.
  - pos2: num=2, seg=24.
  - pos3: num=1, seg=79.
  - `an` cycles 1110→1101→1011→0111.
- Snapshot coherence: change `nums` from 16'h1234 to 16'h9876 while pos=1. Required: digits 2 and 3 still show 2 and 1. The next frame shows 6, 7, 8, 9.
- Blanking, `blank_en=1`:
  - `nums=16'h0050`: digits 3 and 2 give seg=7F; digit1 seg=12; digit0 seg=40.
  - `nums=16'h0000`: only digit0 lit, seg=40.
  - `nums=16'h0005`: digits 3..1 blank.
- Prescaler and enable: SCAN_DIV=3. Each `pos` value is held exactly 3 cycles. Pull `en=0` for 5 cycles: `pos` frozen and `an=1111`. After `en` returns high, the scan resumes with `pos+1` after 3 cycles.
- Full decode sweep: drive digit0 with 0..F one frame each. `seg` must match the decode list exactly.
